regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of registers (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 36, register width in bits.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default $clog2(NUM_REGS), register index width.
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-005 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports i_rs1, i_rs2  input  ADDRESS_WIDTH  read indices.
REQ-008 SHALL have ports o_rs1_data, o_rs2_data  output  DATA_WIDTH  read data.
REQ-009 SHALL have ports o_rs1_pend, o_rs2_pend  output  1  addressed register has an outstanding allocation.
REQ-010 SHALL have ports i_wen  input  1, i_rd  input  ADDRESS_WIDTH, i_wdata  input  DATA_WIDTH  write port.
REQ-011 SHALL have ports i_alloc  input  1, i_alloc_rd  input  ADDRESS_WIDTH  mark register pending.
REQ-012 SHALL have port i_clr  input  1  start sequential scrub.
REQ-013 SHALL have port o_clr_busy  output  1  scrub in progress.

Function
REQ-014 Reads SHALL be combinational: o_rsN_data = reg[i_rsN], o_rsN_pend = pend[i_rsN].
REQ-015 With i_wen high and state IDLE, reg[i_rd] SHALL take i_wdata and pend[i_rd] SHALL clear at the next edge.
REQ-016 With i_alloc high and state IDLE, pend[i_alloc_rd] SHALL set at the next edge.
REQ-017 Same-cycle i_wen and i_alloc on the same index: data SHALL be written and pend SHALL end set (alloc wins).
REQ-018 Write to a non-pending register SHALL update data; pend stays 0.
REQ-019 ZERO_REG=1: reads of index 0 SHALL return 0 with pend 0; writes/allocs to index 0 SHALL be ignored.
REQ-020 FSM states IDLE and CLEAR; IDLE->CLEAR when i_clr high in IDLE; CLEAR->IDLE after index NUM_REGS-1 cleared.
REQ-021 In CLEAR, a counter starting at 0 SHALL zero reg[cnt] and pend[cnt] once per cycle, incrementing by 1; o_clr_busy high for exactly NUM_REGS cycles.
REQ-022 In CLEAR, i_wen, i_alloc and i_clr SHALL be ignored; reads SHALL return current (partially scrubbed) contents.
REQ-023 Counter SHALL reset to 0 on entering CLEAR; no wrap beyond NUM_REGS-1.

Reset
REQ-024 On i_rst high at an edge, all registers and pend bits SHALL become 0, FSM SHALL enter IDLE, counter SHALL become 0.
REQ-025 Reset SHALL take priority over write, alloc and scrub, including mid-scrub; o_clr_busy SHALL be 0 the cycle after reset.
REQ-026 After reset, o_rsN_data = 0, o_rsN_pend = 0, o_clr_busy = 0.

Configuration
REQ-027 Macro REGFILE_SB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_SB_BYPASS_EN defined: in IDLE, if i_wen and i_rd == i_rsN (and not zero-reg index 0), o_rsN_data SHALL equal i_wdata and o_rsN_pend SHALL be 0 in the same cycle, unless i_alloc targets the same index (then pend stays as stored).
REQ-029 Without the macro: reads SHALL reflect stored state only; written data visible the cycle after the write.

Verification
REQ-030 Reset, write reg3=36'h123456789, read rs1=3 next cycle -> o_rs1_data=36'h123456789, o_rs1_pend=0.
REQ-031 alloc rd=5, then rs2=5 -> o_rs2_pend=1; write rd=5 data 36'hA -> next cycle pend=0, data=36'hA.
REQ-032 Same-cycle alloc and write to rd=2 data 36'h7 -> next cycle data=36'h7, pend=1.
REQ-033 Fill regs with nonzero, pulse i_clr -> o_clr_busy high 8 cycles; writes ignored during scrub; all regs read 0 afterward.
REQ-034 Assert i_rst during cycle 3 of scrub -> o_clr_busy=0 next cycle, all regs 0; a write one cycle later succeeds.
REQ-035 With REGFILE_SB_BYPASS_EN: write rd=1 data 36'hF while rs1=1 -> o_rs1_data=36'hF same cycle; without macro, old value that cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a sequential scrub FSM.
// Optional write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int NUM_REGS      = 8,
    parameter int DATA_WIDTH    = 36,
    parameter int ADDRESS_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_REG      = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDRESS_WIDTH-1:0] i_rs1,
    input  logic [ADDRESS_WIDTH-1:0] i_rs2,
    output logic [DATA_WIDTH-1:0]    o_rs1_data,
    output logic [DATA_WIDTH-1:0]    o_rs2_data,
    output logic                     o_rs1_pend,
    output logic                     o_rs2_pend,
    input  logic                     i_wen,
    input  logic [ADDRESS_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_alloc,
    input  logic [ADDRESS_WIDTH-1:0] i_alloc_rd,
    input  logic                     i_clr,
    output logic                     o_clr_busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NUM_REGS - 1);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0]      pend;
    logic                     wr_ok, alloc_ok;

    // Index 0 swallows writes and allocations when it is the hardwired zero register.
    assign wr_ok    = i_wen   && !(ZERO_REG != 0 && i_rd == '0);
    assign alloc_ok = i_alloc && !(ZERO_REG != 0 && i_alloc_rd == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_clr) state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    assign o_clr_busy = (state == CLEAR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
            pend[cnt] <= 1'b0;
            cnt       <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
            if (wr_ok) begin
                regs[i_rd] <= i_wdata;
                pend[i_rd] <= 1'b0;
            end
            // Placed after the write so a same-index allocation leaves pend set.
            if (alloc_ok) pend[i_alloc_rd] <= 1'b1;
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic fwd1, fwd2, alloc_hit1, alloc_hit2;
    assign fwd1       = (state == IDLE) && wr_ok && (i_rd == i_rs1);
    assign fwd2       = (state == IDLE) && wr_ok && (i_rd == i_rs2);
    assign alloc_hit1 = alloc_ok && (i_alloc_rd == i_rs1);
    assign alloc_hit2 = alloc_ok && (i_alloc_rd == i_rs2);
`endif

    always_comb begin
        o_rs1_data = regs[i_rs1];
        o_rs1_pend = pend[i_rs1];
        o_rs2_data = regs[i_rs2];
        o_rs2_pend = pend[i_rs2];
`ifdef REGFILE_SB_BYPASS_EN
        if (fwd1) begin
            o_rs1_data = i_wdata;
            if (!alloc_hit1) o_rs1_pend = 1'b0;
        end
        if (fwd2) begin
            o_rs2_data = i_wdata;
            if (!alloc_hit2) o_rs2_pend = 1'b0;
        end
`endif
        if (ZERO_REG != 0 && i_rs1 == '0) begin
            o_rs1_data = '0;
            o_rs1_pend = 1'b0;
        end
        if (ZERO_REG != 0 && i_rs2 == '0) begin
            o_rs2_data = '0;
            o_rs2_pend = 1'b0;
        end
    end

endmodule
